countdown_ctrl: RTL and testbench

Countdown sequencer for the BCD minute/second setpoint path. It gates the add/sub keys to the setpoint block so the setpoint changes only while idle. On start it loads the 8-bit BCD setpoint (01..60) and decrements it once per prescaled tick to 00. It then drives a timed alarm and returns to idle, with pause, resume and abort along the way. It sits between the debounced keypad and the setpoint block on one side and the display/alarm drivers on the other.

---
 rtl/countdown_ctrl_if.sv | 24 ++
 rtl/countdown_ctrl.sv | 118 +++++++++++
 tb/tb_countdown_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_ctrl_if.sv
// Keypad/setpoint inputs and display/alarm outputs of the countdown sequencer.
// master = keypad/setpoint side driving keys, slave = countdown_ctrl.
interface countdown_ctrl_if;
    logic       key_start;
    logic       key_stop;
    logic       key_add_in;
    logic       key_sub_in;
    logic [7:0] set_t;
    logic       key_add_out;
    logic       key_sub_out;
    logic [7:0] remain_t;
    logic [1:0] state;
    logic       alarm;

    modport master (
        output key_start, key_stop, key_add_in, key_sub_in, set_t,
        input  key_add_out, key_sub_out, remain_t, state, alarm
    );

    modport slave (
        input  key_start, key_stop, key_add_in, key_sub_in, set_t,
        output key_add_out, key_sub_out, remain_t, state, alarm
    );
endinterface

// File: rtl/countdown_ctrl.sv
// BCD countdown sequencer: load setpoint, decrement per prescaled tick, timed alarm.
// Outputs registered one edge after the sampled key/tick; key gating is combinational; no backpressure.
module countdown_ctrl #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int ALARM_TICKS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    countdown_ctrl_if.slave  ifc
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ACNT_LAST = AW'(ALARM_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    remain_q, remain_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          alarm_q, alarm_d;

    logic set_valid;
    logic tick;

    assign set_valid = (ifc.set_t[7:4] <= 4'd9) && (ifc.set_t[3:0] <= 4'd9) &&
                       (ifc.set_t != 8'h00) && (ifc.set_t <= 8'h60);
    assign tick      = (presc_q == PRESC_MAX);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        presc_d  = presc_q;
        acnt_d   = acnt_q;
        alarm_d  = alarm_q;
        unique case (state_q)
            IDLE: begin
                remain_d = ifc.set_t;
                if (!ifc.key_stop && ifc.key_start && set_valid) begin
                    presc_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Stop freezes the prescaler, so a coincident tick is replayed on resume.
                if (ifc.key_stop) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    presc_d = '0;
                    if (remain_q == 8'h01) begin
                        remain_d = 8'h00;
                        alarm_d  = 1'b1;
                        acnt_d   = '0;
                        state_d  = DONE;
                    end else if (remain_q[3:0] == 4'd0) begin
                        remain_d = {remain_q[7:4] - 4'd1, 4'd9};
                    end else begin
                        remain_d = {remain_q[7:4], remain_q[3:0] - 4'd1};
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            PAUSE: begin
                if (ifc.key_stop) begin
                    state_d = IDLE;
                end else if (ifc.key_start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (ifc.key_stop || ifc.key_start) begin
                    alarm_d = 1'b0;
                    state_d = IDLE;
                end else if (tick) begin
                    presc_d = '0;
                    if (acnt_q == ACNT_LAST) begin
                        alarm_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= 8'h00;
            presc_q  <= '0;
            acnt_q   <= '0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            presc_q  <= presc_d;
            acnt_q   <= acnt_d;
            alarm_q  <= alarm_d;
        end
    end

    assign ifc.key_add_out = ifc.key_add_in & (state_q == IDLE);
    assign ifc.key_sub_out = ifc.key_sub_in & (state_q == IDLE);
    assign ifc.remain_t    = remain_q;
    assign ifc.state       = state_q;
    assign ifc.alarm       = alarm_q;
endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with TICK_DIV=4, ALARM_TICKS=2.
module tb_countdown_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    countdown_ctrl_if bus ();

    countdown_ctrl #(.TICK_DIV(4), .ALARM_TICKS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.key_start = 1'b1;
        step();
        bus.key_start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.key_stop = 1'b1;
        step();
        bus.key_stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_start = 0; bus.key_stop = 0; bus.key_add_in = 0; bus.key_sub_in = 0;
        bus.set_t = 8'h05;
        #3;
        tests++;
        if (bus.state !== 2'b00 || bus.remain_t !== 8'h00 || bus.alarm !== 1'b0) begin
            fails++;
            $display("FAIL reset_init: state=%b remain=%h alarm=%b, want 00/00/0", bus.state, bus.remain_t, bus.alarm);
        end
        step();
        rst_n = 1'b1;
        step();
        tests++;
        if (bus.remain_t !== 8'h05) begin
            fails++;
            $display("FAIL idle_follow: remain=%h, want 05", bus.remain_t);
        end
        pulse_start();
        step();
        step();
        tests++;
        if (bus.state !== 2'b01) begin
            fails++;
            $display("FAIL run_before_reset: state=%b, want 01", bus.state);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.state !== 2'b00 || bus.remain_t !== 8'h00 || bus.alarm !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: state=%b remain=%h alarm=%b, want 00/00/0", bus.state, bus.remain_t, bus.alarm);
        end
        bus.set_t = 8'h02;
        #2;
        rst_n = 1'b1;
        step();
        tests++;
        if (bus.state !== 2'b00 || bus.remain_t !== 8'h02) begin
            fails++;
            $display("FAIL reset_release: state=%b remain=%h, want 00/02", bus.state, bus.remain_t);
        end
    endtask

    task automatic test_bcd_borrow();
        logic [7:0] exp_tab [13];
        exp_tab = '{8'h12, 8'h12, 8'h12, 8'h12, 8'h11, 8'h11, 8'h11, 8'h11,
                    8'h10, 8'h10, 8'h10, 8'h10, 8'h09};
        bus.set_t = 8'h12;
        step();
        pulse_start();
        tests++;
        if (bus.state !== 2'b01 || bus.remain_t !== 8'h12) begin
            fails++;
            $display("FAIL borrow_load: state=%b remain=%h, want 01/12", bus.state, bus.remain_t);
        end
        for (int i = 1; i <= 12; i++) begin
            step();
            tests++;
            if (bus.remain_t !== exp_tab[i]) begin
                fails++;
                $display("FAIL borrow_edge%0d: remain=%h, want %h", i, bus.remain_t, exp_tab[i]);
            end
        end
        pulse_stop();
        pulse_stop();
        tests++;
        if (bus.state !== 2'b00) begin
            fails++;
            $display("FAIL borrow_abort: state=%b, want 00", bus.state);
        end
    endtask

    task automatic test_completion();
        bus.set_t = 8'h02;
        step();
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 4) begin
                tests++;
                if (bus.remain_t !== 8'h01) begin
                    fails++;
                    $display("FAIL done_mid: remain=%h, want 01", bus.remain_t);
                end
            end
        end
        tests++;
        if (bus.remain_t !== 8'h00 || bus.state !== 2'b11 || bus.alarm !== 1'b1) begin
            fails++;
            $display("FAIL done_enter: state=%b remain=%h alarm=%b, want 11/00/1", bus.state, bus.remain_t, bus.alarm);
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            tests++;
            if (i < 8) begin
                if (bus.alarm !== 1'b1 || bus.state !== 2'b11 || bus.remain_t !== 8'h00) begin
                    fails++;
                    $display("FAIL alarm_hold%0d: state=%b alarm=%b remain=%h, want 11/1/00", i, bus.state, bus.alarm, bus.remain_t);
                end
            end else begin
                if (bus.alarm !== 1'b0 || bus.state !== 2'b00) begin
                    fails++;
                    $display("FAIL alarm_end: state=%b alarm=%b, want 00/0", bus.state, bus.alarm);
                end
            end
        end
        step();
        tests++;
        if (bus.remain_t !== 8'h02) begin
            fails++;
            $display("FAIL done_reload: remain=%h, want 02", bus.remain_t);
        end
    endtask

    task automatic test_pause_resume();
        bus.set_t = 8'h05;
        step();
        pulse_start();
        repeat (6) step();
        pulse_stop();
        tests++;
        if (bus.state !== 2'b10 || bus.remain_t !== 8'h04) begin
            fails++;
            $display("FAIL pause_enter: state=%b remain=%h, want 10/04", bus.state, bus.remain_t);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            tests++;
            if (bus.state !== 2'b10 || bus.remain_t !== 8'h04) begin
                fails++;
                $display("FAIL pause_hold%0d: state=%b remain=%h, want 10/04", i, bus.state, bus.remain_t);
            end
        end
        pulse_start();
        tests++;
        if (bus.state !== 2'b01 || bus.remain_t !== 8'h04) begin
            fails++;
            $display("FAIL resume: state=%b remain=%h, want 01/04", bus.state, bus.remain_t);
        end
        step();
        tests++;
        if (bus.remain_t !== 8'h04) begin
            fails++;
            $display("FAIL resume_early: remain=%h, want 04", bus.remain_t);
        end
        step();
        tests++;
        if (bus.remain_t !== 8'h03) begin
            fails++;
            $display("FAIL resume_tick: remain=%h, want 03", bus.remain_t);
        end
        pulse_stop();
        tests++;
        if (bus.state !== 2'b10) begin
            fails++;
            $display("FAIL pause_again: state=%b, want 10", bus.state);
        end
        pulse_stop();
        tests++;
        if (bus.state !== 2'b00) begin
            fails++;
            $display("FAIL abort: state=%b, want 00", bus.state);
        end
    endtask

    task automatic test_gating();
        logic [7:0] bad [4];
        bad = '{8'h00, 8'h6A, 8'h61, 8'hA1};
        bus.set_t = 8'h05;
        step();
        bus.key_add_in = 1'b1;
        bus.key_sub_in = 1'b1;
        #1;
        tests++;
        if (bus.key_add_out !== 1'b1 || bus.key_sub_out !== 1'b1) begin
            fails++;
            $display("FAIL gate_idle: add=%b sub=%b, want 1/1", bus.key_add_out, bus.key_sub_out);
        end
        bus.key_add_in = 1'b0;
        bus.key_sub_in = 1'b0;
        #1;
        tests++;
        if (bus.key_add_out !== 1'b0 || bus.key_sub_out !== 1'b0) begin
            fails++;
            $display("FAIL gate_idle_low: add=%b sub=%b, want 0/0", bus.key_add_out, bus.key_sub_out);
        end
        pulse_start();
        bus.key_add_in = 1'b1;
        bus.key_sub_in = 1'b1;
        #1;
        tests++;
        if (bus.key_add_out !== 1'b0 || bus.key_sub_out !== 1'b0) begin
            fails++;
            $display("FAIL gate_run: add=%b sub=%b, want 0/0", bus.key_add_out, bus.key_sub_out);
        end
        bus.key_add_in = 1'b0;
        bus.key_sub_in = 1'b0;
        pulse_stop();
        pulse_stop();
        for (int i = 0; i < 4; i++) begin
            bus.set_t = bad[i];
            step();
            pulse_start();
            tests++;
            if (bus.state !== 2'b00) begin
                fails++;
                $display("FAIL invalid_%h: state=%b, want 00", bad[i], bus.state);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.set_t = 8'h05;
        step();
        pulse_start();
        repeat (7) step();
        pulse_stop();
        tests++;
        if (bus.state !== 2'b10 || bus.remain_t !== 8'h04) begin
            fails++;
            $display("FAIL stop_on_tick: state=%b remain=%h, want 10/04", bus.state, bus.remain_t);
        end
        repeat (3) step();
        pulse_start();
        tests++;
        if (bus.state !== 2'b01 || bus.remain_t !== 8'h04) begin
            fails++;
            $display("FAIL held_tick_resume: state=%b remain=%h, want 01/04", bus.state, bus.remain_t);
        end
        step();
        tests++;
        if (bus.remain_t !== 8'h03) begin
            fails++;
            $display("FAIL held_tick_fire: remain=%h, want 03", bus.remain_t);
        end
        pulse_stop();
        bus.key_start = 1'b1;
        bus.key_stop  = 1'b1;
        step();
        bus.key_start = 1'b0;
        bus.key_stop  = 1'b0;
        tests++;
        if (bus.state !== 2'b00) begin
            fails++;
            $display("FAIL both_keys_pause: state=%b, want 00", bus.state);
        end
        bus.set_t = 8'h01;
        step();
        pulse_start();
        repeat (4) step();
        tests++;
        if (bus.state !== 2'b11 || bus.alarm !== 1'b1) begin
            fails++;
            $display("FAIL done_01: state=%b alarm=%b, want 11/1", bus.state, bus.alarm);
        end
        pulse_start();
        tests++;
        if (bus.state !== 2'b00 || bus.alarm !== 1'b0) begin
            fails++;
            $display("FAIL start_in_done: state=%b alarm=%b, want 00/0", bus.state, bus.alarm);
        end
        step();
        pulse_start();
        repeat (5) step();
        pulse_stop();
        tests++;
        if (bus.state !== 2'b00 || bus.alarm !== 1'b0 || bus.remain_t !== 8'h00) begin
            fails++;
            $display("FAIL stop_in_done: state=%b alarm=%b remain=%h, want 00/0/00", bus.state, bus.alarm, bus.remain_t);
        end
        step();
        tests++;
        if (bus.remain_t !== 8'h01) begin
            fails++;
            $display("FAIL stop_done_reload: remain=%h, want 01", bus.remain_t);
        end
    endtask

    initial begin
        test_reset();
        test_bcd_borrow();
        test_completion();
        test_pause_resume();
        test_gating();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
